cla_seq_ctrl: RTL
=================

Name: cla_seq_ctrl

Overview:
Sequencer that performs a TOTAL_W-bit addition by time-multiplexing one external SLICE_W-bit carry-lookahead adder slice over NUM_SLICES consecutive cycles.
- Latches operands through a valid/ready input handshake.
- Feeds one slice per cycle, least-significant slice first, and registers the inter-slice carry.
- Assembles the full sum and presents it through a valid/ready output handshake.
- Sits between the arithmetic request source and the shared adder slice in the wide-add datapath.

Parameters:
TOTAL_W, 256, full operand/sum width.
SLICE_W, 64, width of the external adder slice; must divide TOTAL_W exactly.
NUM_SLICES, TOTAL_W/SLICE_W, derived localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  controller can accept operands
a  input  TOTAL_W  operand A
b  input  TOTAL_W  operand B
cin  input  1  carry into bit 0
slc_a  output  SLICE_W  current slice of A to adder
slc_b  output  SLICE_W  current slice of B to adder
slc_cin  output  1  carry into current slice
slc_sum  input  SLICE_W  combinational sum from adder slice
slc_cout  input  1  combinational carry-out from adder slice
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  TOTAL_W  full result
cout  output  1  carry out of MSB

Behaviour:
- One clock domain: clk. Reset: rst, synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, slice index=0, carry reg=0. slc_a, slc_b and slc_cin drive 0 whenever the FSM is not in RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b, cin into operand registers; carry reg<=cin; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - slc_a = A_reg[idx*SLICE_W +: SLICE_W], slc_b likewise, slc_cin = carry reg.
  - Each cycle: sum[idx slice] <= slc_sum; carry reg <= slc_cout; idx <= idx+1.
  - When idx==NUM_SLICES-1: cout<=slc_cout, out_valid<=1, go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready=0 in DONE, so there is no overlap between a result and a new request.
- Latency:
  - Operand accept edge -> out_valid high after NUM_SLICES edges (4 with default parameters).
  - Minimum issue interval: NUM_SLICES+2 cycles with out_ready held high.
- Arithmetic: result = (a + b + cin) mod 2^TOTAL_W; cout = bit TOTAL_W of the full sum. The carry chain is exact; no wrap-around of idx beyond NUM_SLICES-1.
- Edge cases:
  - Input changes after acceptance have no effect; operands are registered.
  - in_valid during RUN/DONE is ignored and stays pending; it is accepted at the first IDLE cycle.
  - out_ready held low: DONE is held indefinitely, outputs stable.
  - rst asserted mid-RUN or in DONE: next edge returns to reset values; the partial result is discarded and no out_valid pulse occurs.
  - NUM_SLICES==1: RUN lasts a single cycle.

Optional Feature:
Macro CLA_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands.
  - When sub=1, B_reg <= ~b and the initial carry <= 1, ignoring cin. Result = a - b mod 2^TOTAL_W; cout=1 means no borrow.
- Undefined: the port is absent and the block performs addition only.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, sum=0, cout=0, slc_* all 0.
- a=1, b=2^64-1 (low slice all ones), cin=0 -> carry ripples into slice 1; sum=2^64, cout=0; out_valid 4 cycles after accept.
- a=b=2^256-1, cin=1 -> sum=2^256-1, cout=1.
- Result issued with out_ready=0 for 5 cycles, in_valid held high with new operands -> sum stable, in_ready=0 throughout. After out_ready, the second request is accepted on the first IDLE cycle and produces the correct result.
- rst pulsed at RUN idx=2 -> out_valid never asserts; state IDLE, sum=0 next cycle; a subsequent add of 5+7 returns 12.
- With CLA_SEQ_SUB_EN: a=10, b=3, sub=1 -> sum=7, cout=1. a=3, b=10, sub=1 -> sum=2^256-7, cout=0.

Source files
------------

// File: rtl/cla_seq_ctrl_if.sv
// Handshake and adder-slice bundle for cla_seq_ctrl.
// The sub bit exists only when CLA_SEQ_SUB_EN is defined.
interface cla_seq_if #(
  parameter int TOTAL_W = 256,
  parameter int SLICE_W = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [TOTAL_W-1:0] a;
  logic [TOTAL_W-1:0] b;
  logic               cin;
`ifdef CLA_SEQ_SUB_EN
  logic               sub;
`endif
  logic [SLICE_W-1:0] slc_a;
  logic [SLICE_W-1:0] slc_b;
  logic               slc_cin;
  logic [SLICE_W-1:0] slc_sum;
  logic               slc_cout;
  logic               out_valid;
  logic               out_ready;
  logic [TOTAL_W-1:0] sum;
  logic               cout;

  // Request source plus the external adder slice.
  modport master (
`ifdef CLA_SEQ_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, slc_sum, slc_cout, out_ready,
    input  in_ready, slc_a, slc_b, slc_cin, out_valid, sum, cout
  );

  modport slave (
`ifdef CLA_SEQ_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, slc_sum, slc_cout, out_ready,
    output in_ready, slc_a, slc_b, slc_cin, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Wide adder sequencer: one shared SLICE_W carry-lookahead slice, one slice per cycle, LSB first.
// Optional subtract mode when CLA_SEQ_SUB_EN is defined.
module cla_seq_ctrl #(
  parameter int TOTAL_W = 256,
  parameter int SLICE_W = 64
) (
  input logic     clk,
  input logic     rst,
  cla_seq_if.slave io_bus
);
  localparam int NUM_SLICES = TOTAL_W / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [TOTAL_W-1:0] r_a;
  logic [TOTAL_W-1:0] r_b;
  logic [TOTAL_W-1:0] r_sum;
  logic               r_cout;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [SLICE_W-1:0] r_slc_a;
  logic [SLICE_W-1:0] r_slc_b;
  logic               r_slc_cin;

  logic [TOTAL_W-1:0] w_b_in;
  logic               w_cin_in;
  logic [IDX_W-1:0]   w_idx_nxt;

  function automatic logic [SLICE_W-1:0] f_slice(input logic [TOTAL_W-1:0] v,
                                                 input logic [IDX_W-1:0]   i);
    f_slice = v[int'(i)*SLICE_W +: SLICE_W];
  endfunction

`ifdef CLA_SEQ_SUB_EN
  // Subtract is a + ~b + 1; cin is ignored in that mode.
  assign w_b_in   = io_bus.sub ? ~io_bus.b : io_bus.b;
  assign w_cin_in = io_bus.sub ? 1'b1 : io_bus.cin;
`else
  assign w_b_in   = io_bus.b;
  assign w_cin_in = io_bus.cin;
`endif

  assign w_idx_nxt = r_idx + IDX_W'(1);

  // r_slc_cin doubles as the inter-slice carry register; the slice outputs are
  // preloaded one edge ahead so they are registered yet aligned with r_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_slc_a     <= '0;
      r_slc_b     <= '0;
      r_slc_cin   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.in_valid && r_in_ready) begin
            r_a        <= io_bus.a;
            r_b        <= w_b_in;
            r_idx      <= '0;
            r_slc_a    <= io_bus.a[SLICE_W-1:0];
            r_slc_b    <= w_b_in[SLICE_W-1:0];
            r_slc_cin  <= w_cin_in;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sum[int'(r_idx)*SLICE_W +: SLICE_W] <= io_bus.slc_sum;
          if (r_idx == LAST_IDX) begin
            r_cout      <= io_bus.slc_cout;
            r_out_valid <= 1'b1;
            r_slc_a     <= '0;
            r_slc_b     <= '0;
            r_slc_cin   <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_idx     <= w_idx_nxt;
            r_slc_a   <= f_slice(r_a, w_idx_nxt);
            r_slc_b   <= f_slice(r_b, w_idx_nxt);
            r_slc_cin <= io_bus.slc_cout;
            r_state   <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_slc_a     <= '0;
          r_slc_b     <= '0;
          r_slc_cin   <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.sum       = r_sum;
  assign io_bus.cout      = r_cout;
  assign io_bus.slc_a     = r_slc_a;
  assign io_bus.slc_b     = r_slc_b;
  assign io_bus.slc_cin   = r_slc_cin;
endmodule
